mod_counter: RTL and testbench
==============================

Name: mod_counter

Overview:
- Parametrised successor to the basic free-running 8-bit counter.
- Adds:
  - programmable modulus (wrap point) and up/down direction
  - synchronous load
  - count enable with programmable prescaler
  - registered terminal-count pulse and sticky wrap flag
- Used as a timebase/event counter in generated designs and driven from sequence-based testbenches.

Parameters:
WIDTH, 8, width of count, load_val and modulus
PRESCALE_W, 4, width of prescale input and internal prescaler counter

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  synchronous reset, active-high
en  input  1  count enable; prescaler advances only when high
up  input  1  direction: 1 = increment, 0 = decrement
load  input  1  synchronous load strobe
load_val  input  WIDTH  value loaded on load
modulus  input  WIDTH  terminal value; count range is 0..modulus inclusive
prescale  input  PRESCALE_W  count advances once per (prescale+1) enabled cycles
clr_sticky  input  1  clears wrapped
count  output  WIDTH  current count (registered)
tc  output  1  one-cycle terminal-count pulse (registered)
wrapped  output  1  sticky flag, set on any wrap

Behaviour:
- Reset: rst high at a rising edge sets count=0, prescaler pcnt=0, tc=0, wrapped=0. All other inputs are ignored that cycle.
- Priority each edge: rst > load > tick.
- Internal tick:
  - tick = en & (pcnt == prescale).
  - When en=1: pcnt <= (pcnt==prescale) ? 0 : pcnt+1.
  - When en=0: pcnt holds.
  - prescale=0 gives tick every enabled cycle.
  - If prescale is lowered below the current pcnt, the next enabled cycle sets pcnt<=pcnt+1, so pcnt wraps through 2^PRESCALE_W-1 to 0 before the next tick. This is accepted behaviour; the bench must not flag it.
- Load:
  - count <= min(load_val, modulus); pcnt <= 0; tc <= 0.
  - wrapped is unaffected, except that clr_sticky still applies.
  - A load in the same cycle as a tick discards the tick.
- Up tick (up=1):
  - count >= modulus: count <= 0, tc <= 1.
  - Otherwise: count <= count+1, tc <= 0.
- Down tick (up=0):
  - count == 0: count <= modulus, tc <= 1.
  - count > modulus (modulus changed downward): count <= modulus, tc <= 0.
  - Otherwise: count <= count-1, tc <= 0.
- No tick and no load: count holds, tc <= 0.
- tc timing: high for exactly one cycle, in the cycle after the wrapping edge, i.e. coincident with the wrapped count value appearing on count.
- wrapped:
  - Set when tc is set.
  - Cleared by clr_sticky.
  - Same-cycle set and clear: set wins.
- modulus = 0: count stays 0; tc pulses on every tick.
- modulus = 2^WIDTH-1: full binary range, no overflow beyond WIDTH bits. All arithmetic is WIDTH bits, unsigned.
- Latency: inputs sampled at edge N are reflected on count/tc/wrapped after edge N. No combinational input-to-output paths.
- Mid-run changes:
  - A direction change applies to the next tick.
  - A modulus change mid-run takes effect on the next tick, per the rules above.

Test Plan:
1. Reset/up count: hold rst 2 cycles, then en=1, up=1, modulus=4, prescale=0 -> count 0,1,2,3,4,0,1; tc high only when count returns to 0; wrapped=1 after first wrap.
2. Prescale: prescale=2, modulus=3, en=1 -> count steps every 3rd cycle (0,0,0,1,1,1,2...). Toggle en low for 5 cycles mid-run -> count and pcnt frozen, resume with no lost or extra step.
3. Down wrap: load load_val=1, up=0, modulus=5 -> count 1,0,5,4; tc pulse coincident with count=5.
4. Load clamp/priority: modulus=6, load=1, load_val=200 in the same cycle as a tick -> count=6, tc=0. Then load=1 and rst=1 together -> count=0.
5. Sticky collision: force a wrap edge with clr_sticky=1 in the same cycle -> wrapped stays 1. Next cycle clr_sticky=1 with no wrap -> wrapped=0.
6. Modulus shrink: count=9, up=0, modulus changed to 3 -> next tick count=3, tc=0. With up=1, count=9, modulus=3 -> next tick count=0, tc=1.

Source files
------------

// File: rtl/mod_counter.sv
// mod_counter: programmable-modulus up/down counter with prescaler.
//
// Counts over 0..modulus inclusive, advancing once per (prescale+1)
// enabled cycles. Supports a synchronous load (clamped to modulus), a
// registered one-cycle terminal-count pulse and a sticky wrap flag.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        synchronous reset, active high
//   en         count enable; the prescaler only advances while high
//   up         direction, 1 = increment, 0 = decrement
//   load       synchronous load strobe (beats a tick in the same cycle)
//   load_val   value to load, clamped to modulus
//   modulus    terminal value of the count range
//   prescale   count advances once per (prescale+1) enabled cycles
//   clr_sticky clears wrapped (a same-cycle wrap wins)
//   count      current count (registered)
//   tc         terminal-count pulse, coincident with the wrapped value
//   wrapped    sticky flag, set on any wrap
module mod_counter #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic [WIDTH-1:0]      modulus,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  clr_sticky,
  output logic [WIDTH-1:0]      count,
  output logic                  tc,
  output logic                  wrapped
);

  localparam logic [WIDTH-1:0]      CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PRESCALE_W-1:0] PS_ONE  = {{(PRESCALE_W-1){1'b0}}, 1'b1};

  logic [PRESCALE_W-1:0] pcnt, pcnt_nxt;
  logic [WIDTH-1:0]      count_nxt;
  logic                  tc_nxt, wrapped_nxt, tick;

  always_comb begin
    count_nxt = count;
    pcnt_nxt  = pcnt;
    tc_nxt    = 1'b0;
    tick      = en && (pcnt == prescale);

    // If prescale drops below pcnt, pcnt simply runs on and wraps
    // through all-ones back to zero before the next tick.
    if (en) pcnt_nxt = tick ? '0 : pcnt + PS_ONE;

    if (load) begin
      // Load restarts the prescaler and swallows any coincident tick.
      count_nxt = (load_val > modulus) ? modulus : load_val;
      pcnt_nxt  = '0;
    end else if (tick) begin
      if (up) begin
        // >= also catches a count stranded above a shrunken modulus.
        if (count >= modulus) begin
          count_nxt = '0;
          tc_nxt    = 1'b1;
        end else begin
          count_nxt = count + CNT_ONE;
        end
      end else begin
        if (count == '0) begin
          count_nxt = modulus;
          tc_nxt    = 1'b1;
        end else if (count > modulus) begin
          // Modulus moved below the count: snap down without a wrap.
          count_nxt = modulus;
        end else begin
          count_nxt = count - CNT_ONE;
        end
      end
    end

    // Set wins over a same-cycle clear.
    wrapped_nxt = tc_nxt | (wrapped & ~clr_sticky);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      pcnt    <= '0;
      tc      <= 1'b0;
      wrapped <= 1'b0;
    end else begin
      count   <= count_nxt;
      pcnt    <= pcnt_nxt;
      tc      <= tc_nxt;
      wrapped <= wrapped_nxt;
    end
  end

endmodule

// File: tb/tb_mod_counter.sv
// Directed bench for mod_counter: hand-computed expected values.
module tb_mod_counter;

  logic       clk = 1'b0;
  logic       rst, en, up, load, clr_sticky;
  logic [7:0] load_val, modulus, count;
  logic [3:0] prescale;
  logic       tc, wrapped;

  int n_cmp = 0;
  int n_bad = 0;

  mod_counter #(.WIDTH(8), .PRESCALE_W(4)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
    .load_val(load_val), .modulus(modulus), .prescale(prescale),
    .clr_sticky(clr_sticky), .count(count), .tc(tc), .wrapped(wrapped)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle past it before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check count, tc and wrapped in one go.
  task automatic chk3(input string tag, input int c, input int t, input int w);
    chk({tag, ".count"},   count,   c);
    chk({tag, ".tc"},      tc,      t);
    chk({tag, ".wrapped"}, wrapped, w);
  endtask

  initial begin
    int exp_up[6];
    exp_up = '{1, 2, 3, 4, 0, 1};

    rst = 1; en = 0; up = 1; load = 0; clr_sticky = 0;
    load_val = 0; modulus = 0; prescale = 0;

    // 1. reset, then count up with modulus 4
    step(); step();
    chk3("rst", 0, 0, 0);
    rst = 0; en = 1; up = 1; modulus = 4; prescale = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk3($sformatf("up%0d", i), exp_up[i], (i == 4) ? 1 : 0, (i >= 4) ? 1 : 0);
    end

    // 2. prescale 2, modulus 3, with an en gap mid-run
    rst = 1; step(); rst = 0;
    prescale = 2; modulus = 3; en = 1; up = 1;
    step(); chk("ps0", count, 0);
    step(); chk("ps1", count, 0);
    step(); chk("ps2", count, 1);
    step(); chk("ps3", count, 1);   // pcnt now 1
    en = 0;
    for (int i = 0; i < 5; i++) step();
    chk("ps_hold", count, 1);
    en = 1;
    step(); chk("ps_res0", count, 1);  // pcnt 1 -> 2
    step(); chk("ps_res1", count, 2);  // tick
    step(); chk("ps_res2", count, 2);

    // 3. down wrap from load 1, modulus 5
    prescale = 0; modulus = 5; up = 0; load = 1; load_val = 1;
    step(); chk3("dn_ld", 1, 0, 0);
    load = 0;
    step(); chk3("dn0", 0, 0, 0);
    step(); chk3("dn1", 5, 1, 1);
    step(); chk3("dn2", 4, 0, 1);

    // 4. load clamp beats tick; reset beats load
    modulus = 6; load = 1; load_val = 200;
    step(); chk3("ld_clamp", 6, 0, 1);
    rst = 1; load_val = 5;
    step(); chk3("rst_ld", 0, 0, 0);
    rst = 0; load = 0;

    // 5. wrap and clr_sticky on the same edge
    up = 1; modulus = 2; en = 1;
    step(); chk("st0", count, 1);
    step(); chk("st1", count, 2);
    clr_sticky = 1;
    step(); chk3("st_coll", 0, 1, 1);
    step(); chk3("st_clr", 1, 0, 0);
    clr_sticky = 0;

    // 6. modulus shrinks below count
    load = 1; load_val = 9; modulus = 15; en = 0;
    step(); chk("sh_ld0", count, 9);
    load = 0; modulus = 3; up = 0; en = 1;
    step(); chk3("sh_dn", 3, 0, 0);
    load = 1; load_val = 9; modulus = 15; en = 0;
    step(); chk("sh_ld1", count, 9);
    load = 0; modulus = 3; up = 1; en = 1;
    step(); chk3("sh_up", 0, 1, 1);

    // modulus 0: stays at 0, tc every tick
    modulus = 0; clr_sticky = 1;
    step(); chk3("m0a", 0, 1, 1);
    clr_sticky = 0; up = 0;
    step(); chk3("m0b", 0, 1, 1);

    // full range: 255 -> 0 up, 0 -> 255 down
    modulus = 255; load = 1; load_val = 255;
    step(); chk3("fr_ld", 255, 0, 1);
    load = 0; up = 1;
    step(); chk3("fr_up", 0, 1, 1);
    up = 0;
    step(); chk3("fr_dn", 255, 1, 1);
    step(); chk3("fr_dn2", 254, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
